// File: rtl/mbinit_pkg.sv
// Shared constants and types for the MBINIT.REPAIRMB lane-repair controller.
package mbinit_pkg;

  localparam logic [3:0] MSG_START_REQ          = 4'b0001;
  localparam logic [3:0] MSG_START_RESP         = 4'b0010;
  localparam logic [3:0] MSG_END_REQ            = 4'b0011;
  localparam logic [3:0] MSG_END_RESP           = 4'b0100;
  localparam logic [3:0] MSG_APPLY_DEGRADE_REQ  = 4'b0101;
  localparam logic [3:0] MSG_APPLY_DEGRADE_RESP = 4'b0110;

  localparam logic [1:0] LANES_ALL  = 2'b11;
  localparam logic [1:0] LANES_LOW  = 2'b01;
  localparam logic [1:0] LANES_HIGH = 2'b10;
  localparam logic [1:0] LANES_NONE = 2'b00;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_NO_LANES = 2'b10;

  typedef enum logic [3:0] {
    StIdle,
    StStartReq,
    StWStart,
    StD2c,
    StEval,
    StDegReq,
    StWDeg,
    StEndReq,
    StWEnd,
    StDone,
    StError
  } repair_state_e;

  // Response code owed to the partner for a received request; 0 if not a request.
  function automatic logic [3:0] resp_for(input logic [3:0] msg);
    unique case (msg)
      MSG_START_REQ:         resp_for = MSG_START_RESP;
      MSG_APPLY_DEGRADE_REQ: resp_for = MSG_APPLY_DEGRADE_RESP;
      MSG_END_REQ:           resp_for = MSG_END_RESP;
      default:               resp_for = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mbinit_repair_ctrl_if.sv
// Sideband, D2C and status signals between the REPAIRMB controller and its environment.
interface mbinit_repair_ctrl_if #(
  parameter int unsigned NUM_LANES = 16
);
  logic                 i_enable;
  logic                 i_sb_busy;
  logic                 i_rx_valid;
  logic [3:0]           i_rx_msg;
  logic [2:0]           i_rx_info;
  logic                 i_d2c_done;
  logic [NUM_LANES-1:0] i_d2c_result;
  logic                 o_tx_valid;
  logic [3:0]           o_tx_msg;
  logic [2:0]           o_tx_info;
  logic                 o_d2c_en;
  logic                 o_d2c_perlane;
  logic [1:0]           o_functional_lanes;
  logic [1:0]           o_partner_lanes;
  logic                 o_done;
  logic                 o_error;
  logic [1:0]           o_error_code;

  // Controller side.
  modport master (
    input  i_enable, i_sb_busy, i_rx_valid, i_rx_msg, i_rx_info, i_d2c_done, i_d2c_result,
    output o_tx_valid, o_tx_msg, o_tx_info, o_d2c_en, o_d2c_perlane, o_functional_lanes,
           o_partner_lanes, o_done, o_error, o_error_code
  );

  // Environment side (LTSM, sideband, D2C engine).
  modport slave (
    output i_enable, i_sb_busy, i_rx_valid, i_rx_msg, i_rx_info, i_d2c_done, i_d2c_result,
    input  o_tx_valid, o_tx_msg, o_tx_info, o_d2c_en, o_d2c_perlane, o_functional_lanes,
           o_partner_lanes, o_done, o_error, o_error_code
  );
endinterface

// File: rtl/repair_lane_encoder.sv
// Maps per-lane D2C pass/fail results to the functional-lane code (full, low half, high half).
module repair_lane_encoder
  import mbinit_pkg::*;
#(
  parameter int unsigned NUM_LANES = 16
) (
  input  logic [NUM_LANES-1:0] result_i,
  output logic [1:0]           code_o
);

  always_comb begin
    if (&result_i) begin
      code_o = LANES_ALL;
    end else if (&result_i[NUM_LANES/2-1:0]) begin
      code_o = LANES_LOW;
    end else if (&result_i[NUM_LANES-1:NUM_LANES/2]) begin
      code_o = LANES_HIGH;
    end else begin
      code_o = LANES_NONE;
    end
  end

endmodule

// File: rtl/mbinit_repair_ctrl.sv
// MBINIT.REPAIRMB controller: request sequencing with timeout/retry, partner responder,
// and lane-code publication for width degrade.
module mbinit_repair_ctrl
  import mbinit_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  mbinit_repair_ctrl_if.master bus
);

  localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned       RetryW    = $clog2(MAX_RETRY + 2);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRY);

  repair_state_e        state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [RetryW-1:0]    retry_q, retry_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [3:0]           pend_msg_q, pend_msg_d;
  logic [NUM_LANES-1:0] result_q, result_d;
  logic [1:0]           func_q, func_d;
  logic [1:0]           partner_q, partner_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [3:0]           tx_msg_q, tx_msg_d;
  logic [2:0]           tx_info_q, tx_info_d;
  logic                 d2c_en_q, d2c_en_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic [1:0]    enc_code;
  logic          rx_valid;
  logic          local_ok;
  logic [3:0]    w_resp;
  logic [3:0]    w_req;
  logic [2:0]    w_info;
  repair_state_e w_next;
  logic          unused_rx_info;

  assign unused_rx_info = bus.i_rx_info[2];

  repair_lane_encoder #(
    .NUM_LANES(NUM_LANES)
  ) u_lane_encoder (
    .result_i(result_q),
    .code_o  (enc_code)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    pend_valid_d = pend_valid_q;
    pend_msg_d   = pend_msg_q;
    result_d     = result_q;
    func_d       = func_q;
    partner_d    = partner_q;
    err_code_d   = err_code_q;
    tx_valid_d   = 1'b0;
    tx_msg_d     = 4'b0000;
    tx_info_d    = 3'b000;

    rx_valid = bus.i_rx_valid && (state_q != StIdle);
    // A pending response owns the sideband; local requests wait behind it.
    local_ok = !bus.i_sb_busy && !pend_valid_q;

    w_resp = MSG_START_RESP;
    w_req  = MSG_START_REQ;
    w_info = 3'b000;
    w_next = StD2c;
    if (state_q == StWDeg) begin
      w_resp = MSG_APPLY_DEGRADE_RESP;
      w_req  = MSG_APPLY_DEGRADE_REQ;
      w_info = {1'b0, func_q};
      w_next = StEndReq;
    end else if (state_q == StWEnd) begin
      w_resp = MSG_END_RESP;
      w_req  = MSG_END_REQ;
      w_next = StDone;
    end

    if (pend_valid_q && !bus.i_sb_busy) begin
      tx_valid_d   = 1'b1;
      tx_msg_d     = pend_msg_q;
      pend_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.i_enable) state_d = StStartReq;
      end
      StStartReq, StDegReq, StEndReq: begin
        if (local_ok) begin
          tx_valid_d = 1'b1;
          timer_d    = '0;
          retry_d    = '0;
          if (state_q == StStartReq) begin
            tx_msg_d = MSG_START_REQ;
            state_d  = StWStart;
          end else if (state_q == StDegReq) begin
            tx_msg_d  = MSG_APPLY_DEGRADE_REQ;
            tx_info_d = {1'b0, func_q};
            state_d   = StWDeg;
          end else begin
            tx_msg_d = MSG_END_REQ;
            state_d  = StWEnd;
          end
        end
      end
      StWStart, StWDeg, StWEnd: begin
        if (rx_valid && bus.i_rx_msg == w_resp) begin
          state_d = w_next;
        end else if (timer_q == TimerLast) begin
          if (retry_q < RetryMax) begin
            // Timer stays saturated while the resend is blocked by busy or a response.
            if (local_ok) begin
              tx_valid_d = 1'b1;
              tx_msg_d   = w_req;
              tx_info_d  = w_info;
              timer_d    = '0;
              retry_d    = retry_q + 1'b1;
            end
          end else begin
            state_d    = StError;
            err_code_d = ERR_TIMEOUT;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StD2c: begin
        if (bus.i_d2c_done) begin
          result_d = bus.i_d2c_result;
          state_d  = StEval;
        end
      end
      StEval: begin
        func_d = enc_code;
        if (enc_code == LANES_NONE) begin
          state_d    = StError;
          err_code_d = ERR_NO_LANES;
        end else begin
          state_d = StDegReq;
        end
      end
      StDone, StError: ;
      default: state_d = StIdle;
    endcase

    // A newer partner request overwrites any unsent response.
    if (rx_valid && resp_for(bus.i_rx_msg) != 4'b0000) begin
      pend_valid_d = 1'b1;
      pend_msg_d   = resp_for(bus.i_rx_msg);
      if (bus.i_rx_msg == MSG_APPLY_DEGRADE_REQ) partner_d = bus.i_rx_info[1:0];
    end

    if (!bus.i_enable) begin
      state_d      = StIdle;
      timer_d      = '0;
      retry_d      = '0;
      pend_valid_d = 1'b0;
      err_code_d   = ERR_NONE;
      tx_valid_d   = 1'b0;
      tx_msg_d     = 4'b0000;
      tx_info_d    = 3'b000;
    end

    d2c_en_d = (state_d == StD2c);
    done_d   = (state_d == StDone);
    error_d  = (state_d == StError);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      retry_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_msg_q   <= 4'b0000;
      result_q     <= '0;
      func_q       <= LANES_ALL;
      partner_q    <= LANES_ALL;
      err_code_q   <= ERR_NONE;
      tx_valid_q   <= 1'b0;
      tx_msg_q     <= 4'b0000;
      tx_info_q    <= 3'b000;
      d2c_en_q     <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      pend_valid_q <= pend_valid_d;
      pend_msg_q   <= pend_msg_d;
      result_q     <= result_d;
      func_q       <= func_d;
      partner_q    <= partner_d;
      err_code_q   <= err_code_d;
      tx_valid_q   <= tx_valid_d;
      tx_msg_q     <= tx_msg_d;
      tx_info_q    <= tx_info_d;
      d2c_en_q     <= d2c_en_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.o_tx_valid         = tx_valid_q;
  assign bus.o_tx_msg           = tx_msg_q;
  assign bus.o_tx_info          = tx_info_q;
  assign bus.o_d2c_en           = d2c_en_q;
  assign bus.o_d2c_perlane      = d2c_en_q;
  assign bus.o_functional_lanes = func_q;
  assign bus.o_partner_lanes    = partner_q;
  assign bus.o_done             = done_q;
  assign bus.o_error            = error_q;
  assign bus.o_error_code       = err_code_q;

endmodule

// File: tb/tb_mbinit_repair_ctrl.sv
// Directed bench for mbinit_repair_ctrl with a short timeout so retries are quick to reach.
module tb_mbinit_repair_ctrl;
  import mbinit_pkg::*;

  localparam int unsigned NumLanes = 16;
  localparam int unsigned Timeout  = 16;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  mbinit_repair_ctrl_if #(.NUM_LANES(NumLanes)) bus ();

  mbinit_repair_ctrl #(
    .NUM_LANES     (NumLanes),
    .TIMEOUT_CYCLES(Timeout),
    .MAX_RETRY     (2)
  ) dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_rx(input logic [3:0] msg, input logic [2:0] info);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_msg   = msg;
    bus.i_rx_info  = info;
    tick();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_msg   = 4'b0000;
    bus.i_rx_info  = 3'b000;
  endtask

  task automatic d2c_finish(input logic [NumLanes-1:0] res);
    bus.i_d2c_done   = 1'b1;
    bus.i_d2c_result = res;
    tick();
    bus.i_d2c_done   = 1'b0;
    bus.i_d2c_result = '0;
  endtask

  // Waits (bounded) for the next issued message, checks it, then steps past it.
  task automatic expect_tx(input string tag, input logic [3:0] msg, input logic [2:0] info,
                           output int unsigned at);
    for (int i = 0; i < 40 && !bus.o_tx_valid; i++) tick();
    at = cyc;
    check_val({tag, " valid"}, 32'(bus.o_tx_valid), 32'd1);
    check_val({tag, " msg"}, 32'(bus.o_tx_msg), 32'(msg));
    check_val({tag, " info"}, 32'(bus.o_tx_info), 32'(info));
    tick();
  endtask

  task automatic start_to_d2c(input string tag);
    int unsigned t;
    bus.i_enable = 1'b1;
    expect_tx({tag, " start_req"}, MSG_START_REQ, 3'b000, t);
    repeat (2) tick();
    send_rx(MSG_START_RESP, 3'b000);
    check_val({tag, " d2c_en"}, 32'(bus.o_d2c_en), 32'd1);
    check_val({tag, " d2c_perlane"}, 32'(bus.o_d2c_perlane), 32'd1);
  endtask

  task automatic abort();
    bus.i_enable = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int unsigned t0, t1, t2, te, n_tx;
    bus.i_enable     = 1'b0;
    bus.i_sb_busy    = 1'b0;
    bus.i_rx_valid   = 1'b0;
    bus.i_rx_msg     = 4'b0000;
    bus.i_rx_info    = 3'b000;
    bus.i_d2c_done   = 1'b0;
    bus.i_d2c_result = '0;
    repeat (3) tick();

    check_val("rst functional", 32'(bus.o_functional_lanes), 32'd3);
    check_val("rst partner", 32'(bus.o_partner_lanes), 32'd3);
    check_val("rst tx_valid", 32'(bus.o_tx_valid), 32'd0);
    check_val("rst d2c_en", 32'(bus.o_d2c_en), 32'd0);
    check_val("rst done", 32'(bus.o_done), 32'd0);
    check_val("rst error", 32'(bus.o_error), 32'd0);
    check_val("rst error_code", 32'(bus.o_error_code), 32'd0);
    rst_n = 1'b1;
    tick();

    // All lanes pass, full handshake.
    start_to_d2c("t1");
    d2c_finish(16'hFFFF);
    check_val("t1 d2c_en fall", 32'(bus.o_d2c_en), 32'd0);
    expect_tx("t1 deg_req", MSG_APPLY_DEGRADE_REQ, 3'b011, t0);
    check_val("t1 functional", 32'(bus.o_functional_lanes), 32'd3);
    repeat (3) tick();
    send_rx(MSG_APPLY_DEGRADE_RESP, 3'b000);
    expect_tx("t1 end_req", MSG_END_REQ, 3'b000, t0);
    repeat (4) tick();
    send_rx(MSG_END_RESP, 3'b000);
    check_val("t1 done", 32'(bus.o_done), 32'd1);
    check_val("t1 error", 32'(bus.o_error), 32'd0);
    bus.i_enable = 1'b0;
    tick();
    check_val("t1 done clear", 32'(bus.o_done), 32'd0);
    check_val("t1 functional kept", 32'(bus.o_functional_lanes), 32'd3);
    tick();

    // Lower half only.
    start_to_d2c("t2");
    d2c_finish(16'h00FF);
    expect_tx("t2 deg_req", MSG_APPLY_DEGRADE_REQ, 3'b001, t0);
    check_val("t2 functional", 32'(bus.o_functional_lanes), 32'd1);
    abort();

    // Abort during D2C.
    start_to_d2c("t7");
    bus.i_enable = 1'b0;
    tick();
    check_val("t7 d2c_en off", 32'(bus.o_d2c_en), 32'd0);
    check_val("t7 functional kept", 32'(bus.o_functional_lanes), 32'd1);
    check_val("t7 done", 32'(bus.o_done), 32'd0);
    tick();

    // Partner start_req while local start_req is blocked: response goes first.
    bus.i_sb_busy = 1'b1;
    bus.i_enable  = 1'b1;
    tick();
    send_rx(MSG_START_REQ, 3'b000);
    tick();
    bus.i_sb_busy = 1'b0;
    expect_tx("t6 start_resp", MSG_START_RESP, 3'b000, t0);
    expect_tx("t6 start_req", MSG_START_REQ, 3'b000, t1);
    check_val("t6 back to back", 32'(t1 - t0), 32'd1);
    abort();

    // Partner apply_degrade_req during local W_DEG with sideband busy.
    start_to_d2c("t5");
    d2c_finish(16'hFFFF);
    expect_tx("t5 deg_req", MSG_APPLY_DEGRADE_REQ, 3'b011, t0);
    bus.i_sb_busy = 1'b1;
    send_rx(MSG_APPLY_DEGRADE_REQ, 3'b010);
    check_val("t5 partner", 32'(bus.o_partner_lanes), 32'd2);
    n_tx = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.o_tx_valid) n_tx++;
    end
    check_val("t5 quiet while busy", n_tx, 32'd0);
    bus.i_sb_busy = 1'b0;
    expect_tx("t5 deg_resp", MSG_APPLY_DEGRADE_RESP, 3'b000, t1);
    send_rx(MSG_APPLY_DEGRADE_RESP, 3'b000);
    expect_tx("t5 end_req", MSG_END_REQ, 3'b000, t2);
    abort();

    // No usable half.
    start_to_d2c("t3");
    d2c_finish(16'h7F7F);
    tick();
    check_val("t3 error", 32'(bus.o_error), 32'd1);
    check_val("t3 error_code", 32'(bus.o_error_code), 32'd2);
    check_val("t3 functional", 32'(bus.o_functional_lanes), 32'd0);
    n_tx = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.o_tx_valid) n_tx++;
    end
    check_val("t3 no tx", n_tx, 32'd0);
    bus.i_enable = 1'b0;
    tick();
    check_val("t3 error clear", 32'(bus.o_error), 32'd0);
    check_val("t3 error_code clear", 32'(bus.o_error_code), 32'd0);
    tick();

    // Partner never answers start_req: two resends, then timeout error.
    bus.i_enable = 1'b1;
    expect_tx("t4 start_req 1", MSG_START_REQ, 3'b000, t0);
    expect_tx("t4 start_req 2", MSG_START_REQ, 3'b000, t1);
    check_val("t4 spacing 1", 32'(t1 - t0), 32'(Timeout));
    expect_tx("t4 start_req 3", MSG_START_REQ, 3'b000, t2);
    check_val("t4 spacing 2", 32'(t2 - t1), 32'(Timeout));
    n_tx = 0;
    for (int i = 0; i < 40 && !bus.o_error; i++) begin
      tick();
      if (bus.o_tx_valid) n_tx++;
    end
    te = cyc;
    check_val("t4 error", 32'(bus.o_error), 32'd1);
    check_val("t4 error_code", 32'(bus.o_error_code), 32'd1);
    check_val("t4 error delay", 32'(te - t2), 32'(Timeout));
    check_val("t4 no 4th send", n_tx, 32'd0);
    abort();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
